// File: rtl/note_recorder.sv
// note_recorder: records hit note fields into a track buffer and plays them back to a sound player.
// Optional feature macro: NOTE_RECORDER_LOOP_EN (playback wraps to entry 0 instead of ending).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   en                                block enable, low forces IDLE
//   rec_start, play_start, stop       control pulses
//   hit, octave_in, note_in, length_in  capture pulse and fields
//   note_done                         player finished the current note
//   play_req, octave_out, note_out, length_out  playback request and fields
//   track_len, busy, full, overflow, done       status
module note_recorder #(
   parameter int DEPTH  = 32,
   parameter int OCT_W  = 2,
   parameter int NOTE_W = 3,
   parameter int LEN_W  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       rec_start,
   input  logic                       play_start,
   input  logic                       stop,
   input  logic                       hit,
   input  logic [OCT_W-1:0]           octave_in,
   input  logic [NOTE_W-1:0]          note_in,
   input  logic [LEN_W-1:0]           length_in,
   input  logic                       note_done,
   output logic                       play_req,
   output logic [OCT_W-1:0]           octave_out,
   output logic [NOTE_W-1:0]          note_out,
   output logic [LEN_W-1:0]           length_out,
   output logic [$clog2(DEPTH):0]     track_len,
   output logic                       busy,
   output logic                       full,
   output logic                       overflow,
   output logic                       done
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int W  = OCT_W + NOTE_W + LEN_W;
   typedef enum logic [1:0] {IDLE, RECORD, PLAY, WAIT} state_t;
   state_t state, state_n;
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_q, fields, fields_n;
   logic [AW-1:0] rd_idx, idx_n;
   logic [LW-1:0] len_n, nxt;
   logic ph, ph_n, ovf_n, req_n, done_n, wr;
   assign nxt = {1'b0, rd_idx} + LW'(1);
   assign octave_out = fields[W-1 -: OCT_W];
   assign note_out   = fields[LEN_W +: NOTE_W];
   assign length_out = fields[LEN_W-1:0];
   always_comb begin
      state_n  = state;
      len_n    = track_len;
      idx_n    = rd_idx;
      ph_n     = 1'b0;
      ovf_n    = overflow;
      req_n    = 1'b0;
      done_n   = 1'b0;
      fields_n = fields;
      wr       = 1'b0;
      if (!en) state_n = IDLE;
      else case (state)
         IDLE:
            if (rec_start) begin
               state_n = RECORD;
               len_n   = '0;
               ovf_n   = 1'b0;
            end else if (play_start) begin
               idx_n = '0;
               if (track_len == '0) done_n = 1'b1;
               else state_n = PLAY;
            end
         RECORD:
            if (stop) state_n = IDLE;
            else if (hit) begin
               if (track_len == LW'(DEPTH)) ovf_n = 1'b1;
               else begin
                  wr    = 1'b1;
                  len_n = track_len + LW'(1);
               end
            end
         // first PLAY cycle loads rd_q from the buffer, second presents it
         PLAY:
            if (stop) state_n = IDLE;
            else if (!ph) ph_n = 1'b1;
            else begin
               req_n    = 1'b1;
               fields_n = rd_q;
               state_n  = WAIT;
            end
         WAIT:
            if (stop) state_n = IDLE;
            else if (note_done) begin
               if (nxt < track_len) begin
                  idx_n   = rd_idx + AW'(1);
                  state_n = PLAY;
               end else begin
`ifdef NOTE_RECORDER_LOOP_EN
                  idx_n   = '0;
                  state_n = PLAY;
`else
                  idx_n   = rd_idx + AW'(1);
                  done_n  = 1'b1;
                  state_n = IDLE;
`endif
               end
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         track_len <= '0;
         rd_idx    <= '0;
         ph        <= 1'b0;
         overflow  <= 1'b0;
         play_req  <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         full      <= 1'b0;
         fields    <= '0;
      end else begin
         state     <= state_n;
         track_len <= len_n;
         rd_idx    <= idx_n;
         ph        <= ph_n;
         overflow  <= ovf_n;
         play_req  <= req_n;
         done      <= done_n;
         busy      <= state_n != IDLE;
         full      <= len_n == LW'(DEPTH);
         fields    <= fields_n;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[track_len[AW-1:0]] <= {octave_in, note_in, length_in};
      rd_q <= mem[rd_idx];
   end
endmodule
